// File: rtl/cache_perf_monitor.sv
// Cache performance monitor: per-channel access/miss/stall/max-latency counters,
// global cycle and retire counters, RUN/FROZEN halt tracking and registered readout.
module cache_perf_monitor #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned LAT_W  = 16,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              hlt,
   input  logic              retire,
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] hit,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [1:0]        rd_field,
   output logic [CNT_W-1:0]  rd_data,
   output logic [CNT_W-1:0]  cycles,
   output logic [CNT_W-1:0]  retired,
   output logic              frozen,
   output logic              ovf
);

   typedef enum logic {G_RUN, G_FROZEN} g_state_e;
   typedef enum logic {CH_IDLE, CH_MISS} ch_state_e;

   g_state_e         g_q, g_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic [CNT_W-1:0] rd_q, rd_d;
   logic             ovf_q, ovf_d;

   ch_state_e        st_q    [NUM_CH];
   ch_state_e        st_d    [NUM_CH];
   logic [CNT_W-1:0] acc_q   [NUM_CH];
   logic [CNT_W-1:0] acc_d   [NUM_CH];
   logic [CNT_W-1:0] miss_q  [NUM_CH];
   logic [CNT_W-1:0] miss_d  [NUM_CH];
   logic [CNT_W-1:0] stall_q [NUM_CH];
   logic [CNT_W-1:0] stall_d [NUM_CH];
   logic [LAT_W-1:0] lat_q   [NUM_CH];
   logic [LAT_W-1:0] lat_d   [NUM_CH];
   logic [LAT_W-1:0] max_q   [NUM_CH];
   logic [LAT_W-1:0] max_d   [NUM_CH];

   logic             count_en;
   logic             inc_ov;

   // Saturating increment; MSB of the result flags an attempt at all-ones.
   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? {1'b1, v} : {1'b0, v + CNT_W'(1)};
   endfunction

   // Next-state: global FSM, channel FSMs, counters and readout mux.
   always_comb begin
      g_d      = g_q;
      cyc_d    = cyc_q;
      ret_d    = ret_q;
      ovf_d    = ovf_q;
      rd_d     = '0;
      inc_ov   = 1'b0;
      count_en = en && (g_q == G_RUN);
      for (int c = 0; c < NUM_CH; c++) begin
         st_d[c]    = st_q[c];
         acc_d[c]   = acc_q[c];
         miss_d[c]  = miss_q[c];
         stall_d[c] = stall_q[c];
         lat_d[c]   = lat_q[c];
         max_d[c]   = max_q[c];
      end

      // Readout always samples pre-update values; unmatched channel yields zero.
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch == CH_W'(c)) begin
            case (rd_field)
               2'd0:    rd_d = acc_q[c];
               2'd1:    rd_d = miss_q[c];
               2'd2:    rd_d = stall_q[c];
               default: rd_d = CNT_W'(max_q[c]);
            endcase
         end
      end

      if (clr) begin
         g_d   = G_RUN;
         cyc_d = '0;
         ret_d = '0;
         ovf_d = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            st_d[c]    = CH_IDLE;
            acc_d[c]   = '0;
            miss_d[c]  = '0;
            stall_d[c] = '0;
            lat_d[c]   = '0;
            max_d[c]   = '0;
         end
      end else if (count_en) begin
         if (hlt) g_d = G_FROZEN;
         {inc_ov, cyc_d} = sat_inc(cyc_q);
         ovf_d = ovf_d | inc_ov;
         if (retire) begin
            {inc_ov, ret_d} = sat_inc(ret_q);
            ovf_d = ovf_d | inc_ov;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            case (st_q[c])
               CH_IDLE: begin
                  if (req[c]) begin
                     {inc_ov, acc_d[c]} = sat_inc(acc_q[c]);
                     ovf_d = ovf_d | inc_ov;
                     if (!hit[c]) begin
                        {inc_ov, miss_d[c]} = sat_inc(miss_q[c]);
                        ovf_d = ovf_d | inc_ov;
                        {inc_ov, stall_d[c]} = sat_inc(stall_q[c]);
                        ovf_d = ovf_d | inc_ov;
                        lat_d[c] = LAT_W'(1);
                        st_d[c]  = CH_MISS;
                     end
                  end
               end
               default: begin
                  if (req[c] && !hit[c]) begin
                     {inc_ov, stall_d[c]} = sat_inc(stall_q[c]);
                     ovf_d = ovf_d | inc_ov;
                     if (!(&lat_q[c])) lat_d[c] = lat_q[c] + LAT_W'(1);
                  end else begin
                     // A fill records latency; an abort (req dropped) does not.
                     if (req[c] && (lat_q[c] > max_q[c])) max_d[c] = lat_q[c];
                     lat_d[c] = '0;
                     st_d[c]  = CH_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q   <= G_RUN;
         cyc_q <= '0;
         ret_q <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            st_q[c]    <= CH_IDLE;
            acc_q[c]   <= '0;
            miss_q[c]  <= '0;
            stall_q[c] <= '0;
            lat_q[c]   <= '0;
            max_q[c]   <= '0;
         end
      end else begin
         g_q   <= g_d;
         cyc_q <= cyc_d;
         ret_q <= ret_d;
         rd_q  <= rd_d;
         ovf_q <= ovf_d;
         for (int c = 0; c < NUM_CH; c++) begin
            st_q[c]    <= st_d[c];
            acc_q[c]   <= acc_d[c];
            miss_q[c]  <= miss_d[c];
            stall_q[c] <= stall_d[c];
            lat_q[c]   <= lat_d[c];
            max_q[c]   <= max_d[c];
         end
      end
   end

   assign rd_data = rd_q;
   assign cycles  = cyc_q;
   assign retired = ret_q;
   assign ovf     = ovf_q;
   assign frozen  = (g_q == G_FROZEN);

endmodule
